// File: rtl/gate_level_pkg.sv
// Shared constants and the per-bit gate result record for the gate_level block.
// The optional NOR output is enabled by defining GATE_LEVEL_NOR_EN.
package gate_level_pkg;

  localparam int MAX_WIDTH = 64;

`ifdef GATE_LEVEL_NOR_EN
  localparam int NUM_GATES = 7;

  typedef struct packed {
    logic g_and;
    logic g_or;
    logic g_not_a;
    logic g_xor;
    logic g_xnor;
    logic g_nand;
    logic g_nor;
  } gate_bits_t;
`else
  localparam int NUM_GATES = 6;

  typedef struct packed {
    logic g_and;
    logic g_or;
    logic g_not_a;
    logic g_xor;
    logic g_xnor;
    logic g_nand;
  } gate_bits_t;
`endif

endpackage

// File: rtl/gate_cell.sv
// One-bit netlist of the basic two-input gates, built purely from primitives.
// Adds a NOR primitive when GATE_LEVEL_NOR_EN is defined.
module gate_cell
  import gate_level_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output gate_bits_t y
);

  and  u_and  (y.g_and,   a, b);
  or   u_or   (y.g_or,    a, b);
  not  u_not  (y.g_not_a, a);
  xor  u_xor  (y.g_xor,   a, b);
  xnor u_xnor (y.g_xnor,  a, b);
  nand u_nand (y.g_nand,  a, b);
`ifdef GATE_LEVEL_NOR_EN
  nor  u_nor  (y.g_nor,   a, b);
`endif

endmodule

// File: rtl/gate_level.sv
// Registered bank of bitwise gate functions over a and b, one cycle latency.
// Defining GATE_LEVEL_NOR_EN adds the registered nor_g output.
module gate_level
  import gate_level_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_g,
  output logic [WIDTH-1:0] or_g,
  output logic [WIDTH-1:0] not_a_g,
  output logic [WIDTH-1:0] xor_g,
  output logic [WIDTH-1:0] xnor_g,
  output logic [WIDTH-1:0] nand_g,
`ifdef GATE_LEVEL_NOR_EN
  output logic [WIDTH-1:0] nor_g,
`endif
  output logic             out_valid
);

  gate_bits_t cell_y [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gate_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .y (cell_y[i])
    );
  end

  // Results only advance on a valid cycle; out_valid always tracks in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_g     <= '0;
      or_g      <= '0;
      not_a_g   <= '0;
      xor_g     <= '0;
      xnor_g    <= '0;
      nand_g    <= '0;
`ifdef GATE_LEVEL_NOR_EN
      nor_g     <= '0;
`endif
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          and_g[i]   <= cell_y[i].g_and;
          or_g[i]    <= cell_y[i].g_or;
          not_a_g[i] <= cell_y[i].g_not_a;
          xor_g[i]   <= cell_y[i].g_xor;
          xnor_g[i]  <= cell_y[i].g_xnor;
          nand_g[i]  <= cell_y[i].g_nand;
`ifdef GATE_LEVEL_NOR_EN
          nor_g[i]   <= cell_y[i].g_nor;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_level.sv
// Directed bench for gate_level at WIDTH 1, 4 and 8 sharing clock, reset and in_valid.
module tb_gate_level;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;

  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic [0:0] and1, or1, nota1, xor1, xnor1, nand1;
  logic [3:0] and4, or4, nota4, xor4, xnor4, nand4;
  logic [7:0] and8, or8, nota8, xor8, xnor8, nand8;
  logic       v1, v4, v8;
`ifdef GATE_LEVEL_NOR_EN
  logic [0:0] nor1;
  logic [3:0] nor4;
  logic [7:0] nor8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_level #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .and_g(and1), .or_g(or1), .not_a_g(nota1), .xor_g(xor1),
    .xnor_g(xnor1), .nand_g(nand1),
`ifdef GATE_LEVEL_NOR_EN
    .nor_g(nor1),
`endif
    .out_valid(v1)
  );

  gate_level #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .and_g(and4), .or_g(or4), .not_a_g(nota4), .xor_g(xor4),
    .xnor_g(xnor4), .nand_g(nand4),
`ifdef GATE_LEVEL_NOR_EN
    .nor_g(nor4),
`endif
    .out_valid(v4)
  );

  gate_level #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .and_g(and8), .or_g(or8), .not_a_g(nota8), .xor_g(xor8),
    .xnor_g(xnor8), .nand_g(nand8),
`ifdef GATE_LEVEL_NOR_EN
    .nor_g(nor8),
`endif
    .out_valid(v8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // WIDTH=1 outputs packed as {and, or, not_a, xor, xnor, nand}.
  function automatic logic [5:0] w1_pack();
    return {and1, or1, nota1, xor1, xnor1, nand1};
  endfunction

  logic [7:0] e_and, e_or, e_nota, e_xor, e_xnor, e_nand, e_nor;
  logic       e_v;
  logic       rv;
  logic [7:0] ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF; a8 = 8'hFF; b8 = 8'hFF;

    // Reset wins over in_valid
    tick();
    check("rst_w1_outs", {58'd0, w1_pack()}, 64'd0);
    check("rst_w1_valid", {63'd0, v1}, 64'd0);
    check("rst_w4_and_or", {56'd0, and4, or4}, 64'd0);
    check("rst_w4_rest", {48'd0, nota4, xor4, xnor4, nand4}, 64'd0);
    check("rst_w4_valid", {63'd0, v4}, 64'd0);
`ifdef GATE_LEVEL_NOR_EN
    check("rst_w4_nor", {60'd0, nor4}, 64'd0);
`endif

    // Truth table back-to-back, first result one edge after reset drops
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; tick();
    check("tt_00", {58'd0, w1_pack()}, 64'b001011);
    check("tt_00_valid", {63'd0, v1}, 64'd1);
    a1 = 1'b0; b1 = 1'b1; tick();
    check("tt_01", {58'd0, w1_pack()}, 64'b011101);
    check("tt_01_valid", {63'd0, v1}, 64'd1);
    a1 = 1'b1; b1 = 1'b0; tick();
    check("tt_10", {58'd0, w1_pack()}, 64'b010101);
    a1 = 1'b1; b1 = 1'b1; tick();
    check("tt_11", {58'd0, w1_pack()}, 64'b110010);
    check("tt_11_valid", {63'd0, v1}, 64'd1);

    // Hold: capture 1/0, then three idle cycles with changed operands
    a1 = 1'b1; b1 = 1'b0; tick();
    check("hold_capture", {58'd0, w1_pack()}, 64'b010101);
    in_valid = 1'b0; a1 = 1'b1; b1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_outs_%0d", k), {58'd0, w1_pack()}, 64'b010101);
      check($sformatf("hold_valid_%0d", k), {63'd0, v1}, 64'd0);
    end

    // WIDTH=4 directed vector
    in_valid = 1'b1; a4 = 4'b1100; b4 = 4'b1010; tick();
    check("w4_and",   {60'd0, and4},  64'b1000);
    check("w4_or",    {60'd0, or4},   64'b1110);
    check("w4_not_a", {60'd0, nota4}, 64'b0011);
    check("w4_xor",   {60'd0, xor4},  64'b0110);
    check("w4_xnor",  {60'd0, xnor4}, 64'b1001);
    check("w4_nand",  {60'd0, nand4}, 64'b0111);
    check("w4_valid", {63'd0, v4},    64'd1);
`ifdef GATE_LEVEL_NOR_EN
    check("w4_nor",   {60'd0, nor4},  64'b0001);
`endif

    // Reset mid-stream discards the in-flight result
    a1 = 1'b1; b1 = 1'b1; rst = 1'b1; tick();
    check("mid_rst_outs", {58'd0, w1_pack()}, 64'd0);
    check("mid_rst_valid", {63'd0, v1}, 64'd0);
    rst = 1'b0; in_valid = 1'b0; tick();
    check("post_rst_idle_outs", {58'd0, w1_pack()}, 64'd0);
    check("post_rst_idle_valid", {63'd0, v1}, 64'd0);
    in_valid = 1'b1; tick();
    check("post_rst_first", {58'd0, w1_pack()}, 64'b110010);
    check("post_rst_first_valid", {63'd0, v1}, 64'd1);

    // Random WIDTH=8 stream against a bitwise reference model
    rst = 1'b1; tick();
    rst = 1'b0;
    e_and = '0; e_or = '0; e_nota = '0; e_xor = '0; e_xnor = '0; e_nand = '0; e_nor = '0;
    e_v = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      rv = ($urandom_range(0, 7) != 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      in_valid = rv; a8 = ra; b8 = rb;
      tick();
      if (rv) begin
        e_and = ra & rb; e_or = ra | rb; e_nota = ~ra;
        e_xor = ra ^ rb; e_xnor = ~(ra ^ rb); e_nand = ~(ra & rb); e_nor = ~(ra | rb);
      end
      e_v = rv;
      check($sformatf("rnd_%0d_outs", k),
            {8'd0, and8, or8, nota8, xor8, xnor8, nand8, 7'd0, v8},
            {8'd0, e_and, e_or, e_nota, e_xor, e_xnor, e_nand, 7'd0, e_v});
`ifdef GATE_LEVEL_NOR_EN
      check($sformatf("rnd_%0d_nor", k), {56'd0, nor8}, {56'd0, e_nor});
`endif
      if (v8) begin
        check($sformatf("rnd_%0d_inv", k),
              {40'd0, nand8, xnor8, or8},
              {40'd0, ~and8, ~xor8, (and8 | xor8)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
